keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, synchronises and debounces the row lines, and encodes each debounced key press as one ASCII character. It sits directly upstream of the LCD driver. Its data/valid outputs feed the driver's data_i/data_valid_i, and the driver's device_ready_o returns as this block's device_ready_i. The top level maps column_o/row_i onto the column_io/row_io pads; rows are pulled up externally.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/kp_debounce.sv | 35 +++
 rtl/keypad_scanner.sv | 130 +++++++++++++
 tb/tb_keypad_scanner.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// ASCII key map, FSM state encoding and counter sizing helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StEmit,
        StReleaseDb
    } kp_state_e;

    // Indexed by {row, col}; entry 0 is row 0 / column 0.
    localparam logic [15:0][7:0] KEY_MAP = {
        8'h44, 8'h23, 8'h30, 8'h2A,  // r3: D # 0 *
        8'h43, 8'h39, 8'h38, 8'h37,  // r2: C 9 8 7
        8'h42, 8'h36, 8'h35, 8'h34,  // r1: B 6 5 4
        8'h41, 8'h33, 8'h32, 8'h31   // r0: A 3 2 1
    };

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Index of the lowest row line pulled low; callers guarantee at least one is low.
    function automatic logic [1:0] first_low(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Stability counter: done_o pulses on the DEBOUNCE_CNT-th consecutive enabled cycle
// where sense_i matches level_i. Any mismatch or disable restarts the count.
module kp_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 20000,
    parameter int unsigned CNT_W        = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic enable_i,
    input  logic sense_i,
    input  logic level_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable;

    always_comb begin
        stable = enable_i && (sense_i == level_i);
        done_o = stable && (cnt_q == CNT_LAST);
        cnt_d  = '0;
        if (stable && !done_o) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, press/release debounce
// and ASCII encoding with a valid/ready handshake towards the LCD driver.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 20000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    output logic [3:0] column_o,
    input  logic [3:0] row_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    input  logic       device_ready_i
);

    localparam int unsigned      CNT_W      = cnt_width(SCAN_DIV, DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);

    kp_state_e        state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       key_row_q, key_row_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic             db_enable, db_level, db_sense, db_done;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
        end
    end

    // One counter serves both debounce phases; only the expected level differs.
    always_comb begin
        db_enable = (state_q == StPressDb) || (state_q == StReleaseDb);
        db_level  = (state_q == StReleaseDb);
        db_sense  = row_sync_q[key_row_q];
    end

    kp_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_W       (CNT_W)
    ) u_debounce (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .enable_i(db_enable),
        .sense_i (db_sense),
        .level_i (db_level),
        .done_o  (db_done)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        key_row_d = key_row_q;
        dwell_d   = dwell_q;
        data_d    = data_q;
        valid_d   = valid_q;
        unique case (state_q)
            StScan: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (row_sync_q == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        key_row_d = first_low(row_sync_q);
                        state_d   = StPressDb;
                    end
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            StPressDb: begin
                if (row_sync_q[key_row_q]) begin
                    col_d   = col_q + 2'd1;
                    state_d = StScan;
                end else if (db_done) begin
                    data_d  = KEY_MAP[{key_row_q, col_q}];
                    valid_d = 1'b1;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (device_ready_i) begin
                    valid_d = 1'b0;
                    state_d = StReleaseDb;
                end
            end
            StReleaseDb: begin
                if (db_done) begin
                    col_d   = col_q + 2'd1;
                    state_d = StScan;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StScan;
            col_q     <= 2'd0;
            key_row_q <= 2'd0;
            dwell_q   <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            key_row_q <= key_row_d;
            dwell_q   <= dwell_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        column_o     = ~(4'b0001 << col_q);
        data_o       = data_q;
        data_valid_o = valid_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed corner cases, a per-key table and
// randomized presses scored against a key-map/one-char-per-press model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  column;
    logic [3:0]  row;
    logic [7:0]  data;
    logic        data_valid;
    logic        device_ready = 1'b0;
    logic [15:0] pressed = '0;

    int          total = 0;
    int          bad = 0;
    bit          rand_ready = 1'b0;
    int          valid_cycles = 0;
    logic [7:0]  xfers[$];

    typedef struct {
        int         r;
        int         c;
        logic [7:0] ascii;
    } vec_t;

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .column_o      (column),
        .row_i         (row),
        .data_o        (data),
        .data_valid_o  (data_valid),
        .device_ready_i(device_ready)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && !column[k % 4]) row[k / 4] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && data_valid) valid_cycles <= valid_cycles + 1;
        if (rst_n && data_valid && device_ready) xfers.push_back(data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) device_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int limit, output int n);
        n = 0;
        while (!data_valid && n < limit) begin
            tick(1);
            n++;
        end
        check({name, "_timeout"}, 32'(data_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (data_valid && n < limit) begin
            tick(1);
            n++;
        end
        check({name, "_timeout"}, 32'(data_valid), 32'd0);
    endtask

    function automatic logic [31:0] got_at(input int idx);
        if (idx < xfers.size()) return 32'(xfers[idx]);
        return 32'hFFFF;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[16];
        logic [7:0] exp_q[$];
        string      km;
        int         n, base, vbase, stable, k;

        vecs[0]  = '{0, 0, 8'h31}; vecs[1]  = '{0, 1, 8'h32};
        vecs[2]  = '{0, 2, 8'h33}; vecs[3]  = '{0, 3, 8'h41};
        vecs[4]  = '{1, 0, 8'h34}; vecs[5]  = '{1, 1, 8'h35};
        vecs[6]  = '{1, 2, 8'h36}; vecs[7]  = '{1, 3, 8'h42};
        vecs[8]  = '{2, 0, 8'h37}; vecs[9]  = '{2, 1, 8'h38};
        vecs[10] = '{2, 2, 8'h39}; vecs[11] = '{2, 3, 8'h43};
        vecs[12] = '{3, 0, 8'h2A}; vecs[13] = '{3, 1, 8'h30};
        vecs[14] = '{3, 2, 8'h23}; vecs[15] = '{3, 3, 8'h44};
        km = "123A456B789C*0#D";

        // Reset values, column stepping, asynchronous mid-scan reset.
        device_ready = 1'b1;
        tick(3);
        check("rst_column", 32'(column), 32'hE);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        rst_n = 1'b1;
        tick(3);
        check("step_hold", 32'(column), 32'hE);
        tick(1);
        check("step_c1", 32'(column), 32'hD);
        tick(4);
        check("step_c2", 32'(column), 32'hB);
        tick(4);
        check("step_c3", 32'(column), 32'h7);
        tick(4);
        check("step_wrap", 32'(column), 32'hE);
        tick(8);
        check("step_c2b", 32'(column), 32'hB);
        rst_n = 1'b0;
        #1;
        check("async_rst_column", 32'(column), 32'hE);
        check("async_rst_valid", 32'(data_valid), 32'd0);

        // Clean press of "6": detection 12 edges after reset, valid 8 edges later.
        pressed[1 * 4 + 2] = 1'b1;
        tick(2);
        base = xfers.size();
        rst_n = 1'b1;
        wait_valid("clean", 100, n);
        check("clean_latency", 32'(n), 32'd20);
        check("clean_data", 32'(data), 32'h36);
        tick(1);
        check("clean_valid_drop", 32'(data_valid), 32'd0);
        tick(60);
        check("clean_count", 32'(xfers.size() - base), 32'd1);
        check("clean_xfer", got_at(base), 32'h36);
        pressed = '0;
        tick(30);

        // Bounce on row 0 while column 0 is active.
        rst_n = 1'b0;
        pressed[0] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        vbase = valid_cycles;
        tick(4);
        pressed = '0;
        check("bounce_hold", 32'(column), 32'hE);
        tick(3);
        check("bounce_resume", 32'(column), 32'hD);
        tick(4);
        check("bounce_next", 32'(column), 32'hB);
        tick(40);
        check("bounce_no_valid", 32'(valid_cycles - vbase), 32'd0);

        // Backpressure on "#" with the key released while waiting.
        device_ready = 1'b0;
        rst_n = 1'b0;
        pressed[14] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        base = xfers.size();
        wait_valid("bp", 100, n);
        pressed = '0;
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (data_valid === 1'b1 && data === 8'h23) stable++;
        end
        check("bp_stable", 32'(stable), 32'd50);
        check("bp_no_xfer", 32'(xfers.size() - base), 32'd0);
        device_ready = 1'b1;
        tick(1);
        check("bp_valid_drop", 32'(data_valid), 32'd0);
        check("bp_count", 32'(xfers.size() - base), 32'd1);
        check("bp_xfer", got_at(base), 32'h23);
        check("bp_data_kept", 32'(data), 32'h23);
        tick(30);

        // Reset while a character is pending discards it.
        device_ready = 1'b0;
        pressed[3] = 1'b1;
        base = xfers.size();
        wait_valid("disc", 100, n);
        check("disc_data", 32'(data), 32'h41);
        rst_n = 1'b0;
        #1;
        check("disc_valid", 32'(data_valid), 32'd0);
        check("disc_data_clr", 32'(data), 32'h00);
        pressed = '0;
        tick(2);
        rst_n = 1'b1;
        device_ready = 1'b1;
        tick(40);
        check("disc_no_xfer", 32'(xfers.size() - base), 32'd0);

        // Release bounce on "D": glitches and short high runs must not re-arm.
        base = xfers.size();
        pressed[15] = 1'b1;
        wait_valid("rel", 100, n);
        tick(1);
        check("rel_first", 32'(xfers.size() - base), 32'd1);
        pressed = '0;       tick(4);
        pressed[15] = 1'b1; tick(3);
        pressed = '0;       tick(4);
        pressed[15] = 1'b1; tick(3);
        pressed = '0;       tick(6);
        pressed[15] = 1'b1; tick(40);
        check("rel_no_repeat", 32'(xfers.size() - base), 32'd1);
        pressed = '0;
        tick(20);
        pressed[15] = 1'b1;
        tick(40);
        check("rel_second", 32'(xfers.size() - base), 32'd2);
        check("rel_second_data", got_at(base + 1), 32'h44);
        pressed = '0;
        tick(30);

        // Two keys in column 0: the lower row wins, nothing else follows.
        base = xfers.size();
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        tick(60);
        check("two_count", 32'(xfers.size() - base), 32'd1);
        check("two_data", got_at(base), 32'h31);
        pressed = '0;
        tick(40);
        check("two_after", 32'(xfers.size() - base), 32'd1);

        // Every key once.
        for (int i = 0; i < 16; i++) begin
            base = xfers.size();
            pressed[vecs[i].r * 4 + vecs[i].c] = 1'b1;
            tick(40);
            pressed = '0;
            tick(30);
            check($sformatf("key%0d_count", i), 32'(xfers.size() - base), 32'd1);
            check($sformatf("key%0d_data", i), got_at(base), 32'(vecs[i].ascii));
        end

        // Random keys, hold times and ready pattern.
        base = xfers.size();
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(0, 15));
            exp_q.push_back(km[k]);
            pressed = '0;
            pressed[k] = 1'b1;
            tick(40 + int'($urandom_range(0, 20)));
            pressed = '0;
            wait_idle("rand_idle", 300);
            tick(20);
        end
        rand_ready = 1'b0;
        device_ready = 1'b1;
        check("rand_count", 32'(xfers.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand%0d_data", i), got_at(base + i), 32'(exp_q[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
